// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid buffer: state encoding (which doubles
// as the occupancy value) and the default payload width.
package pipe_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_EMPTY = 2'd0;
  localparam state_t ST_ONE   = 2'd1;
  localparam state_t ST_TWO   = 2'd2;

endpackage

// File: rtl/pipe_skid_buffer_data_reg.sv
// Payload register with load enable; used for both the main and the skid entry
// of the skid buffer.
module data_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: the data entries are reset as well as the state, so out_data reads 0 after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry ready/valid register slice. in_ready and out_valid come straight from
// the state register, so no combinational path crosses the slice.
module pipe_skid_buffer
  import pipe_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 flush,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] xfer_count
);

  state_t           state_q;
  state_t           state_d;
  logic             in_fire;
  logic             out_fire;
  logic             main_load;
  logic             skid_load;
  logic             main_from_skid;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;

  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = state_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_load = 1'b1;
          state_d   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_ready) begin
          main_load = 1'b1;
        end else if (in_fire) begin
          skid_load = 1'b1;
          state_d   = ST_TWO;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_fire) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush squashes everything held and anything arriving this cycle.
    if (flush) begin
      state_d   = ST_EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Downstream has consumed the data on out_fire, so it counts even during flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xfer_count <= '0;
    end else if (out_fire) begin
      xfer_count <= xfer_count + CNT_WIDTH'(1);
    end
  end

  data_reg #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .d     (main_d),
    .q     (out_data)
  );

  data_reg #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Self-checking bench for pipe_skid_buffer: directed scenarios plus a random
// stall run, all checked against a capacity-2 FIFO queue model.
module tb_pipe_skid_buffer;

  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          flush;
  logic [1:0]    occupancy;
  logic [CW-1:0] xfer_count;

  int passed = 0;
  int total  = 0;

  // Reference model: ordered list of held payloads and a wrapping transfer count.
  logic [W-1:0] mq[$];
  int           mcnt;

  pipe_skid_buffer #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .flush      (flush),
    .occupancy  (occupancy),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    mcnt = 0;
  endtask

  // One clock edge; the model applies the handshake rules to the inputs held across it.
  task automatic step();
    bit           fi, fo, fl;
    logic [W-1:0] d;
    fi = in_valid && (mq.size() < 2);
    fo = out_ready && (mq.size() > 0);
    fl = flush;
    d  = in_data;
    @(posedge clk);
    #1;
    if (fo) begin
      void'(mq.pop_front());
      mcnt = (mcnt + 1) % (1 << CW);
    end
    if (fl) mq.delete();
    else if (fi) mq.push_back(d);
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b0; flush = 1'b0;
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
      total++; if (occupancy !== 2'd0) $display("FAIL reset_occupancy: got %0d want 0", occupancy); else passed++;
      total++; if (xfer_count !== '0) $display("FAIL reset_xfer_count: got %0d want 0", xfer_count); else passed++;
    end
    total++; if (out_data !== '0) $display("FAIL reset_out_data: got %h want 0", out_data); else passed++;
    reset = 1'b1; in_valid = 1'b0;
    model_reset();
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_idle_capture: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = W'(i);
      step();
      total++; if (out_valid !== 1'b1) $display("FAIL stream_valid_%0d: got %b want 1", i, out_valid); else passed++;
      total++; if (out_data !== W'(i)) $display("FAIL stream_data_%0d: got %h want %h", i, out_data, i); else passed++;
      total++; if (occupancy !== 2'd1) $display("FAIL stream_occ_%0d: got %0d want 1", i, occupancy); else passed++;
    end
    in_valid = 1'b0;
    step();
    total++; if (xfer_count !== CW'(8)) $display("FAIL stream_count: got %0d want 8", xfer_count); else passed++;
    total++; if (occupancy !== 2'd0) $display("FAIL stream_drain: got %0d want 0", occupancy); else passed++;
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] start;
    logic [W-1:0]  expect_seq [3];
    expect_seq[0] = 32'hA; expect_seq[1] = 32'hB; expect_seq[2] = 32'hC;
    start = xfer_count;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; step();
    in_data = 32'hB; step();
    total++; if (occupancy !== 2'd2) $display("FAIL bp_occ_full: got %0d want 2", occupancy); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready); else passed++;
    in_data = 32'hC;
    repeat (2) step();
    total++; if (occupancy !== 2'd2) $display("FAIL bp_c_rejected: got %0d want 2", occupancy); else passed++;
    total++; if (out_data !== 32'hA) $display("FAIL bp_stable: got %h want a", out_data); else passed++;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++; if (!(out_valid === 1'b1 && out_data === expect_seq[k]))
        $display("FAIL bp_order_%0d: got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, expect_seq[k]);
      else passed++;
      step();
      if (k == 1) in_valid = 1'b0;
    end
    total++; if (xfer_count !== start + CW'(3)) $display("FAIL bp_count: got %0d want %0d", xfer_count, start + CW'(3)); else passed++;
    total++; if (occupancy !== 2'd0) $display("FAIL bp_drain: got %0d want 0", occupancy); else passed++;
  endtask

  task automatic test_flush_two();
    logic [CW-1:0] start;
    start = xfer_count;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'd5; step();
    in_data = 32'd6; step();
    total++; if (occupancy !== 2'd2) $display("FAIL flush2_setup: got %0d want 2", occupancy); else passed++;
    flush = 1'b1; in_data = 32'd7;
    step();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (occupancy !== 2'd0) $display("FAIL flush2_occ: got %0d want 0", occupancy); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL flush2_valid: got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL flush2_in_ready: got %b want 1", in_ready); else passed++;
    out_ready = 1'b1;
    repeat (3) step();
    total++; if (out_valid !== 1'b0) $display("FAIL flush2_no_leak: got %b want 0", out_valid); else passed++;
    total++; if (xfer_count !== start) $display("FAIL flush2_count: got %0d want %0d", xfer_count, start); else passed++;
  endtask

  task automatic test_flush_fire();
    logic [CW-1:0] start;
    start = xfer_count;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'd9; step();
    in_valid = 1'b0;
    total++; if (out_data !== 32'd9) $display("FAIL flushfire_data: got %h want 9", out_data); else passed++;
    out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    total++; if (xfer_count !== start + CW'(1)) $display("FAIL flushfire_count: got %0d want %0d", xfer_count, start + CW'(1)); else passed++;
    total++; if (occupancy !== 2'd0) $display("FAIL flushfire_occ: got %0d want 0", occupancy); else passed++;
  endtask

  task automatic test_random_wrap();
    int cycles;
    int outs;
    // Fill the buffer, then reset asynchronously mid-transfer: everything is dropped.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1111; step();
    in_data = 32'h2222; step();
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (occupancy !== 2'd0) $display("FAIL async_reset_occ: got %0d want 0", occupancy); else passed++;
    total++; if (xfer_count !== '0) $display("FAIL async_reset_count: got %0d want 0", xfer_count); else passed++;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    outs = 0;
    cycles = 0;
    while (outs < 40 && cycles < 2000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = $urandom;
      total++; if (in_ready !== (mq.size() < 2)) $display("FAIL rand_in_ready c%0d: got %b want %b", cycles, in_ready, mq.size() < 2); else passed++;
      total++; if (occupancy !== 2'(mq.size())) $display("FAIL rand_occ c%0d: got %0d want %0d", cycles, occupancy, mq.size()); else passed++;
      total++; if (out_valid !== (mq.size() > 0)) $display("FAIL rand_valid c%0d: got %b want %b", cycles, out_valid, mq.size() > 0); else passed++;
      if (mq.size() > 0) begin
        total++; if (out_data !== mq[0]) $display("FAIL rand_data c%0d: got %h want %h", cycles, out_data, mq[0]); else passed++;
        if (out_ready) outs++;
      end
      step();
      cycles++;
    end
    in_valid = 1'b0;
    total++; if (outs != 40) $display("FAIL rand_timeout: got %0d transfers want 40", outs); else passed++;
    total++; if (xfer_count !== CW'(mcnt)) $display("FAIL rand_count_model: got %0d want %0d", xfer_count, mcnt); else passed++;
    total++; if (xfer_count !== CW'(40 % 16)) $display("FAIL rand_count_wrap: got %0d want 8", xfer_count); else passed++;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    model_reset();
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_two();
    test_flush_fire();
    test_random_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
